// File: rtl/kmac_app_requester.sv
`default_nettype none
// ============================================================================
// Module      : kmac_app_requester
// Description : Initiator for the KMAC application data path. It takes a
//               byte-length command plus 64-bit source words and issues them
//               as valid/data/strb/last beats. It then waits for the done
//               response and returns the unmasked digest with a status code.
// Revision    : 1.0 - initial release
// ============================================================================
module kmac_app_requester #(
    parameter int DATA_W         = 64,
    parameter int DIGEST_W       = 384,
    parameter int LEN_W          = 16,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  start_i,
    input  logic [LEN_W-1:0]      msg_len_i,
    input  logic                  src_valid_i,
    input  logic [DATA_W-1:0]     src_data_i,
    output logic                  src_ready_o,
    output logic                  app_valid_o,
    output logic [DATA_W-1:0]     app_data_o,
    output logic [DATA_W/8-1:0]   app_strb_o,
    output logic                  app_last_o,
    input  logic                  app_ready_i,
    input  logic                  app_done_i,
    input  logic                  app_error_i,
    input  logic [DIGEST_W-1:0]   app_digest_share0_i,
    input  logic [DIGEST_W-1:0]   app_digest_share1_i,
    output logic                  busy_o,
    output logic                  done_o,
    output logic [1:0]            err_code_o,
    output logic [DIGEST_W-1:0]   digest_o
);

    localparam int STRB_W = DATA_W / 8;
    localparam int OFF_W  = $clog2(STRB_W);
    localparam int WCNT_W = LEN_W - OFF_W + 1;
    localparam int TCNT_W = $clog2(TIMEOUT_CYCLES) + 1;
    localparam logic [TCNT_W-1:0] TCNT_MAX = TCNT_W'(TIMEOUT_CYCLES - 1);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_SEND = 2'd1;
    localparam logic [1:0] ST_WAIT = 2'd2;
    localparam logic [1:0] ST_DONE = 2'd3;

    localparam logic [1:0] ERR_OK      = 2'd0;
    localparam logic [1:0] ERR_APP     = 2'd1;
    localparam logic [1:0] ERR_TIMEOUT = 2'd2;
    localparam logic [1:0] ERR_PROTO   = 2'd3;

    logic [1:0]        state;
    logic [LEN_W-1:0]  len_q;
    logic [WCNT_W-1:0] words_rem;
    logic [TCNT_W-1:0] tcnt;

    logic [OFF_W-1:0]  rem;
    logic              zero_len;
    logic              can_issue;
    logic              load;
    logic              accept;
    logic              last_accept;
    logic [STRB_W-1:0] final_strb;
    logic [WCNT_W-1:0] words_init;

    assign rem         = len_q[OFF_W-1:0];
    assign zero_len    = (len_q == '0);
    // Output slot is free when empty or its current beat is leaving this cycle
    assign can_issue   = (state == ST_SEND) && (words_rem != '0) &&
                         (!app_valid_o || app_ready_i);
    // A zero-length message never pulls a source word; its beat is synthesised
    assign src_ready_o = can_issue && !zero_len;
    assign load        = can_issue && (zero_len || src_valid_i);
    assign accept      = app_valid_o && app_ready_i;
    assign last_accept = accept && app_last_o;

    assign busy_o = (state != ST_IDLE);
    assign done_o = (state == ST_DONE);

    // Strobe for the final beat and the beat count derived from the command
    always_comb begin
        final_strb = '0;
        for (int i = 0; i < STRB_W; i++) begin
            final_strb[i] = (rem == '0) || (OFF_W'(i) < rem);
        end
        words_init = WCNT_W'(msg_len_i >> OFF_W) +
                     WCNT_W'(|msg_len_i[OFF_W-1:0]);
        if (msg_len_i == '0) begin
            words_init = WCNT_W'(1);
        end
    end

    // Control FSM, beat output register, timeout counter and result latch
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state       <= ST_IDLE;
            len_q       <= '0;
            words_rem   <= '0;
            tcnt        <= '0;
            app_valid_o <= 1'b0;
            app_data_o  <= '0;
            app_strb_o  <= '0;
            app_last_o  <= 1'b0;
            err_code_o  <= ERR_OK;
            digest_o    <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start_i) begin
                        state      <= ST_SEND;
                        len_q      <= msg_len_i;
                        words_rem  <= words_init;
                        err_code_o <= ERR_OK;
                        digest_o   <= '0;
                    end
                end
                ST_SEND: begin
                    if (app_error_i) begin
                        app_valid_o <= 1'b0;
                        err_code_o  <= ERR_APP;
                        state       <= ST_DONE;
                    end else if (app_done_i && !last_accept) begin
                        app_valid_o <= 1'b0;
                        err_code_o  <= ERR_PROTO;
                        state       <= ST_DONE;
                    end else if (last_accept) begin
                        app_valid_o <= 1'b0;
                        tcnt        <= '0;
                        if (app_done_i) begin
                            digest_o   <= app_digest_share0_i ^ app_digest_share1_i;
                            err_code_o <= ERR_OK;
                            state      <= ST_DONE;
                        end else begin
                            state <= ST_WAIT;
                        end
                    end else if (load) begin
                        app_valid_o <= 1'b1;
                        app_data_o  <= zero_len ? '0 : src_data_i;
                        app_last_o  <= (words_rem == WCNT_W'(1));
                        if (zero_len) begin
                            app_strb_o <= '0;
                        end else if (words_rem == WCNT_W'(1)) begin
                            app_strb_o <= final_strb;
                        end else begin
                            app_strb_o <= '1;
                        end
                        words_rem <= words_rem - WCNT_W'(1);
                    end else if (accept) begin
                        app_valid_o <= 1'b0;
                    end
                end
                ST_WAIT: begin
                    if (app_error_i) begin
                        err_code_o <= ERR_APP;
                        state      <= ST_DONE;
                    end else if (app_done_i) begin
                        digest_o   <= app_digest_share0_i ^ app_digest_share1_i;
                        err_code_o <= ERR_OK;
                        state      <= ST_DONE;
                    end else if (tcnt == TCNT_MAX) begin
                        err_code_o <= ERR_TIMEOUT;
                        state      <= ST_DONE;
                    end else begin
                        tcnt <= tcnt + TCNT_W'(1);
                    end
                end
                ST_DONE: begin
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_kmac_app_requester.sv
`default_nettype none
// ============================================================================
// Module      : tb_kmac_app_requester
// Description : Directed self-checking bench for kmac_app_requester.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_kmac_app_requester;

    localparam int DATA_W   = 64;
    localparam int DIGEST_W = 384;
    localparam int LEN_W    = 16;

    logic                clk_i = 1'b0;
    logic                rst_i = 1'b1;
    logic                start_i = 1'b0;
    logic [LEN_W-1:0]    msg_len_i = '0;
    logic                src_valid_i = 1'b0;
    logic [DATA_W-1:0]   src_data_i = '0;
    logic                src_ready_o;
    logic                app_valid_o;
    logic [DATA_W-1:0]   app_data_o;
    logic [7:0]          app_strb_o;
    logic                app_last_o;
    logic                app_ready_i = 1'b1;
    logic                app_done_i = 1'b0;
    logic                app_error_i = 1'b0;
    logic [DIGEST_W-1:0] share0 = '0;
    logic [DIGEST_W-1:0] share1 = '0;
    logic                busy_o;
    logic                done_o;
    logic [1:0]          err_code_o;
    logic [DIGEST_W-1:0] digest_o;

    kmac_app_requester #(
        .DATA_W(DATA_W), .DIGEST_W(DIGEST_W), .LEN_W(LEN_W), .TIMEOUT_CYCLES(16)
    ) dut (
        .clk_i(clk_i), .rst_i(rst_i), .start_i(start_i), .msg_len_i(msg_len_i),
        .src_valid_i(src_valid_i), .src_data_i(src_data_i), .src_ready_o(src_ready_o),
        .app_valid_o(app_valid_o), .app_data_o(app_data_o), .app_strb_o(app_strb_o),
        .app_last_o(app_last_o), .app_ready_i(app_ready_i), .app_done_i(app_done_i),
        .app_error_i(app_error_i), .app_digest_share0_i(share0),
        .app_digest_share1_i(share1), .busy_o(busy_o), .done_o(done_o),
        .err_code_o(err_code_o), .digest_o(digest_o)
    );

    always #5 clk_i = ~clk_i;

    localparam logic [DIGEST_W-1:0] SH_X   = {6{64'hDEAD_BEEF_0123_4567}};
    localparam logic [DIGEST_W-1:0] SH_Y   = {6{64'h0F0F_0F0F_F0F0_F0F0}};
    localparam logic [DIGEST_W-1:0] DIG_XY = {6{64'hD1A2_B1E0_F1D3_B597}};

    int n_checks = 0;
    int n_errors = 0;

    // Source model and beat monitor state
    logic [63:0] src_words [0:7];
    int          src_n = 0;
    int          src_idx = 0;
    int          src_cnt = 0;
    bit          src_rdy_seen = 0;
    bit          ready_toggle = 0;
    logic [63:0] beat_data [0:15];
    logic [7:0]  beat_strb [0:15];
    logic        beat_last [0:15];
    int          nb = 0;
    int          cyc = 0;
    int          acc_tick = 0;
    int          done_tick = 0;
    int          done_cnt = 0;
    bit          stall_prev = 0;
    logic [72:0] held = '0;

    task automatic check(input string tag, input logic [DIGEST_W-1:0] got,
                         input logic [DIGEST_W-1:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Observe at the falling edge, then advance inputs just after the rising edge
    task automatic tick();
        bit src_fire;
        @(negedge clk_i);
        src_fire = src_valid_i && src_ready_o;
        if (src_ready_o) src_rdy_seen = 1;
        if (stall_prev) check("hold_stable", {app_last_o, app_strb_o, app_data_o}, held);
        stall_prev = app_valid_o && !app_ready_i;
        held = {app_last_o, app_strb_o, app_data_o};
        if (app_valid_o && app_ready_i && nb < 16) begin
            beat_data[nb] = app_data_o;
            beat_strb[nb] = app_strb_o;
            beat_last[nb] = app_last_o;
            if (app_last_o) acc_tick = cyc;
            nb++;
        end
        if (done_o) begin
            if (done_cnt == 0) done_tick = cyc;
            done_cnt++;
        end
        @(posedge clk_i);
        #1;
        cyc++;
        if (src_fire) begin
            src_idx++;
            src_cnt++;
        end
        src_valid_i = (src_idx < src_n);
        src_data_i  = (src_idx < src_n) ? src_words[src_idx] : 64'h0;
        if (ready_toggle) app_ready_i = ~app_ready_i;
    endtask

    task automatic begin_msg(input int len, input int nwords, input logic [63:0] base);
        for (int i = 0; i < 8; i++) src_words[i] = base + 64'(i);
        src_n = nwords; src_idx = 0; src_cnt = 0; src_rdy_seen = 0;
        nb = 0; done_cnt = 0; stall_prev = 0;
        src_valid_i = (nwords > 0);
        src_data_i  = src_words[0];
        msg_len_i   = LEN_W'(len);
        start_i = 1'b1;
        tick();
        start_i = 1'b0;
    endtask

    task automatic run_beats(input int n);
        int b = 0;
        while (nb < n && b < 200) begin tick(); b++; end
        check("beat_count_reached", 32'(nb >= n), 32'd1);
    endtask

    task automatic wait_done();
        int b = 0;
        while (done_cnt == 0 && b < 200) begin tick(); b++; end
        check("done_seen", 32'(done_cnt), 32'd1);
    endtask

    task automatic pulse_done(input logic [DIGEST_W-1:0] x, input logic [DIGEST_W-1:0] y);
        share0 = x; share1 = y; app_done_i = 1'b1;
        tick();
        app_done_i = 1'b0; share0 = '0; share1 = '0;
    endtask

    initial begin
        // Reset state
        tick(); tick();
        check("rst_busy", busy_o, 0);
        check("rst_done", done_o, 0);
        check("rst_valid", app_valid_o, 0);
        check("rst_src_ready", src_ready_o, 0);
        check("rst_err", err_code_o, 0);
        check("rst_digest", digest_o, 0);
        rst_i = 1'b0;
        tick();

        // len=16: two full beats, done arrives 3 cycles into WAIT
        app_ready_i = 1'b1;
        begin_msg(16, 2, 64'hA000_0000_0000_0000);
        check("t1_valid_after_capture", app_valid_o, 0);
        check("t1_busy", busy_o, 1);
        tick();
        check("t1_first_valid_lat2", app_valid_o, 1);
        run_beats(2);
        tick(); tick(); tick();
        check("t1_no_early_done", done_cnt, 0);
        pulse_done(SH_X, SH_Y);
        wait_done();
        check("t1_done_one_cycle", done_o, 0);
        tick(); tick();
        check("t1_done_count", done_cnt, 1);
        check("t1_d0", beat_data[0], 64'hA000_0000_0000_0000);
        check("t1_d1", beat_data[1], 64'hA000_0000_0000_0001);
        check("t1_strb", {beat_strb[0], beat_strb[1]}, 16'hFFFF);
        check("t1_last", {beat_last[0], beat_last[1]}, 2'b01);
        check("t1_src_cnt", src_cnt, 2);
        check("t1_digest", digest_o, DIG_XY);
        check("t1_err", err_code_o, 0);
        check("t1_idle", busy_o, 0);

        // len=13 with app_ready toggling: stalled beats must hold steady
        ready_toggle = 1;
        begin_msg(13, 2, 64'hC000_0000_0000_0010);
        run_beats(2);
        ready_toggle = 0; app_ready_i = 1'b1;
        check("t2_nbeats", nb, 2);
        check("t2_d0", beat_data[0], 64'hC000_0000_0000_0010);
        check("t2_d1", beat_data[1], 64'hC000_0000_0000_0011);
        check("t2_strb", {beat_strb[0], beat_strb[1]}, 16'hFF1F);
        check("t2_last", {beat_last[0], beat_last[1]}, 2'b01);
        check("t2_src_cnt", src_cnt, 2);
        tick();
        pulse_done(SH_Y, '0);
        wait_done();
        check("t2_digest", digest_o, SH_Y);
        check("t2_err", err_code_o, 0);

        // len=0: one synthesised beat, source untouched
        begin_msg(0, 0, 64'h0);
        run_beats(1);
        tick();
        pulse_done(SH_X, '0);
        wait_done();
        check("t3_nbeats", nb, 1);
        check("t3_beat", {beat_last[0], beat_strb[0], beat_data[0]}, {1'b1, 8'h00, 64'h0});
        check("t3_src_ready_never", src_rdy_seen, 0);
        check("t3_err", err_code_o, 0);
        check("t3_digest", digest_o, SH_X);

        // len=8, no done: timeout 16 edges after the last-beat accept edge.
        // Accept seen at falling edge of tick a, done first seen at tick a+17.
        begin_msg(8, 1, 64'hE000_0000_0000_0000);
        run_beats(1);
        wait_done();
        check("t4_strb", beat_strb[0], 8'hFF);
        check("t4_timeout_lat", done_tick - acc_tick, 17);
        check("t4_err", err_code_o, 2);

        // len=32 with app_error after 2 beats; start while busy is ignored
        begin_msg(32, 4, 64'hB000_0000_0000_0000);
        run_beats(2);
        app_error_i = 1'b1; start_i = 1'b1;
        tick();
        app_error_i = 1'b0;
        check("t5_valid_drop", app_valid_o, 0);
        check("t5_done", done_o, 1);
        check("t5_err", err_code_o, 1);
        tick();
        start_i = 1'b0;
        check("t5_busy_start_ignored", busy_o, 0);
        check("t5_done_count", done_cnt, 1);
        tick();
        check("t5_still_idle", busy_o, 0);

        // Reset while in WAIT, then a clean transaction
        begin_msg(8, 1, 64'hF000_0000_0000_0000);
        run_beats(1);
        tick(); tick();
        check("t6_in_wait", busy_o, 1);
        rst_i = 1'b1;
        #1;
        check("t6_rst_busy", busy_o, 0);
        check("t6_rst_last", app_last_o, 0);
        check("t6_rst_strb", app_strb_o, 0);
        check("t6_rst_valid", app_valid_o, 0);
        tick();
        rst_i = 1'b0;
        tick();
        check("t6_no_done_on_rst", done_cnt, 0);
        begin_msg(8, 1, 64'h1234_5678_9ABC_DEF0);
        run_beats(1);
        check("t6_data", beat_data[0], 64'h1234_5678_9ABC_DEF0);
        tick();
        pulse_done(SH_X, SH_Y);
        wait_done();
        check("t6_err", err_code_o, 0);
        check("t6_digest", digest_o, DIG_XY);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/kmac_app_requester.md
Name: kmac_app_requester

Overview:
- Initiator for the KMAC application (KDF) data-path interface.
- Accepts a byte-length command and a stream of 64-bit message words from a local source, then drives them into KMAC as valid/data/strb/last beats.
- Waits for the done response, then returns the unmasked digest (share0 XOR share1) with a status code.
- Sits on the keymgr/ROM side as the counterpart of KMAC's app port.

Parameters:
- DataW, 64, app message word width (bits); StrbW = DataW/8.
- DigestW, 384, digest share width (bits).
- LenW, 16, width of message byte-length command.
- TimeoutCycles, 1024, max cycles waiting for app_done_i after the last beat is accepted.

Ports:
- clk_i  in  1  clock
- rst_i  in  1  asynchronous active-high reset
- start_i  in  1  start pulse; sampled only in IDLE
- msg_len_i  in  LenW  message length in bytes, captured on start
- src_valid_i  in  1  source word valid
- src_data_i  in  DataW  source word, little-endian bytes
- src_ready_o  out  1  source word accepted when valid&ready
- app_valid_o  out  1  app beat valid
- app_data_o  out  DataW  app beat data
- app_strb_o  out  StrbW  app byte strobe
- app_last_o  out  1  final beat marker
- app_ready_i  in  1  KMAC accepts beat
- app_done_i  in  1  KMAC digest ready
- app_error_i  in  1  KMAC error
- app_digest_share0_i  in  DigestW  digest share 0
- app_digest_share1_i  in  DigestW  digest share 1
- busy_o  out  1  high in any state other than IDLE
- done_o  out  1  one-cycle completion pulse
- err_code_o  out  2  0 ok, 1 app error, 2 timeout, 3 protocol (done before last)
- digest_o  out  DigestW  share0^share1, latched on done

Behaviour:
- Reset: every output is 0 and state is IDLE. Reset mid-operation aborts with no done_o pulse; digest_o and err_code_o are cleared.
- States and transitions:
  - IDLE: start_i -> SEND. Capture len, set words = max(1, ceil(len/8)), clear word counter. start_i outside IDLE is ignored.
  - SEND, output register: app_* are registered and held stable while app_valid_o & !app_ready_i.
    - src_ready_o = (state==SEND) & words_remaining>0 & (!app_valid_o | app_ready_i).
    - A source word load sets app_valid_o=1 and decrements words_remaining.
    - Final word: app_last_o=1; app_strb_o = all-ones if len%8==0, else (1<<(len%8))-1.
    - Non-final words use all-ones strobe.
    - len==0: no source word is consumed. A single beat with data 0, strb 0, last 1 is issued.
    - When the last beat is accepted (app_valid_o & app_ready_i & app_last_o): app_valid_o drops next cycle, timeout counter clears, -> WAIT.
    - With no new load, an accepted beat clears app_valid_o. Back-to-back beats sustain one per cycle.
  - WAIT:
    - app_done_i: latch digest_o = share0^share1, err_code_o=0, -> DONE.
    - Counter reaches TimeoutCycles-1 without done: err_code_o=2, -> DONE. The counter saturates and does not wrap.
  - DONE: done_o=1 for exactly one cycle, -> IDLE. digest_o and err_code_o hold until the next start.
- Errors:
  - app_error_i in SEND or WAIT has priority over done and timeout: drop app_valid_o, err_code_o=1, digest_o unchanged, -> DONE.
  - app_done_i in SEND before the last beat is accepted: err_code_o=3, drop app_valid_o, -> DONE.
  - app_done_i and the last-beat acceptance in the same cycle: treated as normal done (code 0, digest latched).
- Latency: start to first app_valid_o = 2 cycles (capture, then load) when src_valid_i is high; last-beat accept to WAIT = 1 cycle; done in WAIT to done_o = 1 cycle.
- app_* inputs are ignored in IDLE and DONE.

Test Plan:
- len=16, src words A,B valid continuously, app_ready_i=1 -> two beats strb FF/FF, last on B. With done 3 cycles later carrying share0=X, share1=Y: done_o pulses once, digest_o=X^Y, err_code_o=0.
- len=13, two words, app_ready_i toggling 1/0 -> beats held stable while stalled; second beat strb=0x1F, last=1; no source word dropped or duplicated.
- len=0 -> single beat data 0, strb 0, last 1; src_ready_o never asserts; normal completion on done.
- len=8, TimeoutCycles=16, no app_done_i -> done_o exactly 16 cycles after last-beat accept, err_code_o=2.
- app_error_i mid-SEND (len=32, after 2 beats) -> app_valid_o drops, err_code_o=1, done_o pulses; a start_i issued while busy is ignored.
- rst_i asserted in WAIT -> all outputs 0 immediately; a new start after release completes with code 0.
